// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants and the decode-to-execute bundle.
// Used by decode_stage, reg_file and decode_stage_if.
package decode_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] rs1_v;
        logic [XLEN-1:0] rs2_v;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic            mem_re;
        logic            mem_we;
        logic            reg_we;
        logic            illegal;
        logic            valid;
    } id_ex_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/write-back inputs and execute-side outputs of the decode stage.
// master = surrounding pipeline, slave = decode_stage.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PC_DE;
    logic            PC_R;
    logic            WB_WE;
    logic [4:0]      WB_A;
    logic [XLEN-1:0] WB_D;

    logic [XLEN-1:0] RS1_V_E;
    logic [XLEN-1:0] RS2_V_E;
    logic [XLEN-1:0] IMM_E;
    logic [XLEN-1:0] PC_E;
    logic [4:0]      RD_E;
    logic [2:0]      FUNCT3_E;
    logic [3:0]      ALU_OP_E;
    logic            ALU_SRC_E;
    logic            BRANCH_E;
    logic            JUMP_E;
    logic            MEM_RE_E;
    logic            MEM_WE_E;
    logic            REG_WE_E;
    logic            ILLEGAL_E;
    logic            VALID_E;

    modport master (
        output InstrD, PC_DE, PC_R, WB_WE, WB_A, WB_D,
        input  RS1_V_E, RS2_V_E, IMM_E, PC_E, RD_E, FUNCT3_E,
        input  ALU_OP_E, ALU_SRC_E, BRANCH_E, JUMP_E,
        input  MEM_RE_E, MEM_WE_E, REG_WE_E, ILLEGAL_E, VALID_E
    );

    modport slave (
        input  InstrD, PC_DE, PC_R, WB_WE, WB_A, WB_D,
        output RS1_V_E, RS2_V_E, IMM_E, PC_E, RD_E, FUNCT3_E,
        output ALU_OP_E, ALU_SRC_E, BRANCH_E, JUMP_E,
        output MEM_RE_E, MEM_WE_E, REG_WE_E, ILLEGAL_E, VALID_E
    );

endinterface

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file, 2 async reads, 1 sync write, x0 hardwired to zero.
// DECODE_BYPASS_EN: same-cycle write data is forwarded to the read ports.
module reg_file
    import decode_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [32];
    logic            wr_en;

    assign wr_en = we && (wa != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
        rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
`ifdef DECODE_BYPASS_EN
        if (wr_en && (wa == ra1)) rd1 = wd;
        if (wr_en && (wa == ra2)) rd2 = wd;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: opcode decode, immediates, operand read, E register.
// Build option DECODE_BYPASS_EN enables write-through forwarding in reg_file.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    logic [XLEN-1:0] inst;
    logic [6:0]      opc;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [XLEN-1:0] rs1_v, rs2_v;
    id_ex_t          d, e;
    logic            ok, rwe;

    assign inst  = bus.InstrD;
    assign opc   = inst[6:0];
    assign rd    = inst[11:7];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};

    reg_file u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (inst[19:15]),
        .ra2 (inst[24:20]),
        .we  (bus.WB_WE),
        .wa  (bus.WB_A),
        .wd  (bus.WB_D),
        .rd1 (rs1_v),
        .rd2 (rs2_v)
    );

    always_comb begin
        d        = '0;
        ok       = 1'b1;
        rwe      = 1'b0;
        d.rs1_v  = rs1_v;
        d.rs2_v  = rs2_v;
        d.pc     = bus.PC_DE;
        d.rd     = rd;
        d.funct3 = f3;
        d.alu_op = ALU_ADD;
        d.valid  = 1'b1;
        unique case (1'b1)
            opc == OPC_LUI,
            opc == OPC_AUIPC: begin
                d.imm = imm_u; d.alu_src = 1'b1; rwe = 1'b1;
            end
            opc == OPC_JAL: begin
                d.imm = imm_j; d.alu_src = 1'b1;
                d.jump = 1'b1; rwe = 1'b1;
            end
            opc == OPC_JALR: begin
                d.imm = imm_i; d.alu_src = 1'b1;
                d.jump = 1'b1; rwe = 1'b1;
                ok = (f3 == 3'b000);
            end
            opc == OPC_BRANCH: begin
                d.imm = imm_b; d.branch = 1'b1;
                ok = (f3 != 3'b010) && (f3 != 3'b011);
            end
            opc == OPC_LOAD: begin
                d.imm = imm_i; d.alu_src = 1'b1;
                d.mem_re = 1'b1; rwe = 1'b1;
                ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            opc == OPC_STORE: begin
                d.imm = imm_s; d.alu_src = 1'b1; d.mem_we = 1'b1;
                ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            end
            opc == OPC_OPIMM: begin
                d.imm = imm_i; d.alu_src = 1'b1; rwe = 1'b1;
                if (f3 == 3'b001) ok = (f7 == F7_BASE);
                if (f3 == 3'b101) ok = (f7 == F7_BASE) || (f7 == F7_ALT);
                if (f3 == 3'b101 && f7[5]) d.alu_op = ALU_SRA;
            end
            opc == OPC_OP: begin
                rwe = 1'b1;
                d.alu_op = {f7[5], f3};
                ok = (f7 == F7_BASE) ||
                     ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101));
            end
            default: ok = 1'b0;
        endcase
        // Illegal ops keep PC/rd/funct3 for the trap path but never act.
        if (!ok) begin
            d.imm     = '0;
            d.alu_op  = ALU_ADD;
            d.alu_src = 1'b0;
            d.branch  = 1'b0;
            d.jump    = 1'b0;
            d.mem_re  = 1'b0;
            d.mem_we  = 1'b0;
            d.illegal = 1'b1;
        end
        d.reg_we = rwe && ok && (rd != 5'd0);
        if (inst == '0) d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.PC_R) e <= '0;
        else                 e <= d;
    end

    assign bus.RS1_V_E   = e.rs1_v;
    assign bus.RS2_V_E   = e.rs2_v;
    assign bus.IMM_E     = e.imm;
    assign bus.PC_E      = e.pc;
    assign bus.RD_E      = e.rd;
    assign bus.FUNCT3_E  = e.funct3;
    assign bus.ALU_OP_E  = e.alu_op;
    assign bus.ALU_SRC_E = e.alu_src;
    assign bus.BRANCH_E  = e.branch;
    assign bus.JUMP_E    = e.jump;
    assign bus.MEM_RE_E  = e.mem_re;
    assign bus.MEM_WE_E  = e.mem_we;
    assign bus.REG_WE_E  = e.reg_we;
    assign bus.ILLEGAL_E = e.illegal;
    assign bus.VALID_E   = e.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table plus corner sequences.
// Build with or without DECODE_BYPASS_EN; expectations follow the macro.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ctl = {src, br, jmp, re, we, rwe, ill, vld}
    typedef struct {
        string       nm;
        bit          full;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  op;
        logic [7:0]  ctl;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        exp_t        e;
    } vec_t;

    exp_t sbq [$];
    vec_t tbl [$];
    int   checks = 0;
    int   errors = 0;

`ifdef DECODE_BYPASS_EN
    localparam logic [31:0] BYP_X2 = 32'hDEADBEEF;
`else
    localparam logic [31:0] BYP_X2 = 32'h11111111;
`endif

    function automatic exp_t ex(string nm, bit full,
                                logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] imm, logic [31:0] pc,
                                logic [4:0] rd, logic [2:0] f3,
                                logic [3:0] op, logic [7:0] ctl);
        exp_t r;
        r.nm = nm; r.full = full; r.rs1 = rs1; r.rs2 = rs2;
        r.imm = imm; r.pc = pc; r.rd = rd; r.f3 = f3;
        r.op = op; r.ctl = ctl;
        return r;
    endfunction

    function automatic exp_t idle(string nm);
        return ex(nm, 1'b0, 0, 0, 0, 0, 5'd0, 3'd0, 4'd0, 8'h00);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic compare();
        exp_t e;
        logic [7:0] ctl;
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e = sbq.pop_front();
        ctl = {bus.ALU_SRC_E, bus.BRANCH_E, bus.JUMP_E, bus.MEM_RE_E,
               bus.MEM_WE_E, bus.REG_WE_E, bus.ILLEGAL_E, bus.VALID_E};
        chk({e.nm, ".ctl"}, {24'd0, ctl}, {24'd0, e.ctl});
        if (e.full) begin
            chk({e.nm, ".rs1"}, bus.RS1_V_E, e.rs1);
            chk({e.nm, ".rs2"}, bus.RS2_V_E, e.rs2);
            chk({e.nm, ".imm"}, bus.IMM_E, e.imm);
            chk({e.nm, ".pc"}, bus.PC_E, e.pc);
            chk({e.nm, ".rd"}, {27'd0, bus.RD_E}, {27'd0, e.rd});
            chk({e.nm, ".f3"}, {29'd0, bus.FUNCT3_E}, {29'd0, e.f3});
            chk({e.nm, ".op"}, {28'd0, bus.ALU_OP_E}, {28'd0, e.op});
        end
    endtask

    task automatic cyc(logic r, logic pcr, logic we, logic [4:0] wa,
                       logic [31:0] wd, logic [31:0] inst,
                       logic [31:0] pc, exp_t e);
        rst        = r;
        bus.PC_R   = pcr;
        bus.WB_WE  = we;
        bus.WB_A   = wa;
        bus.WB_D   = wd;
        bus.InstrD = inst;
        bus.PC_DE  = pc;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic add_vec(logic [31:0] inst, logic [31:0] pc, exp_t e);
        vec_t v;
        v.inst = inst; v.pc = pc; v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] ins;

        add_vec(32'h00500093, 32'h10, ex("addi", 1, 0, 0, 32'd5, 32'h10, 5'd1, 3'd0, 4'h0, 8'h85));
        add_vec(32'h123452B7, 32'h14, ex("lui", 1, 0, 0, 32'h12345000, 32'h14, 5'd5, 3'd5, 4'h0, 8'h85));
        add_vec(32'h002101B3, 32'h18, ex("add", 1, 0, 0, 32'd0, 32'h18, 5'd3, 3'd0, 4'h0, 8'h05));
        add_vec(32'h402101B3, 32'h1C, ex("sub", 1, 0, 0, 32'd0, 32'h1C, 5'd3, 3'd0, 4'h8, 8'h05));
        add_vec(32'h4033D313, 32'h20, ex("srai", 1, 0, 0, 32'h403, 32'h20, 5'd6, 3'd5, 4'hD, 8'h85));
        add_vec(32'h0010D093, 32'h24, ex("srli", 1, 0, 0, 32'd1, 32'h24, 5'd1, 3'd5, 4'h0, 8'h85));
        add_vec(32'h0020A423, 32'h28, ex("sw", 1, 0, 0, 32'd8, 32'h28, 5'd8, 3'd2, 4'h0, 8'h89));
        add_vec(32'hFFC0A203, 32'h2C, ex("lw", 1, 0, 0, 32'hFFFFFFFC, 32'h2C, 5'd4, 3'd2, 4'h0, 8'h95));
        add_vec(32'hFE208CE3, 32'h30, ex("beq", 1, 0, 0, 32'hFFFFFFF8, 32'h30, 5'd25, 3'd0, 4'h0, 8'h41));
        add_vec(32'h010000EF, 32'h34, ex("jal", 1, 0, 0, 32'd16, 32'h34, 5'd1, 3'd0, 4'h0, 8'hA5));
        add_vec(32'h00008067, 32'h38, ex("jalr_x0", 1, 0, 0, 32'd0, 32'h38, 5'd0, 3'd0, 4'h0, 8'hA1));
        add_vec(32'h00001517, 32'h3C, ex("auipc", 1, 0, 0, 32'h1000, 32'h3C, 5'd10, 3'd1, 4'h0, 8'h85));
        add_vec(32'h00000013, 32'h40, ex("nop_rd0", 1, 0, 0, 32'd0, 32'h40, 5'd0, 3'd0, 4'h0, 8'h81));
        add_vec(32'hFFFFFFFF, 32'h44, ex("ill_ones", 0, 0, 0, 0, 0, 5'd0, 3'd0, 4'h0, 8'h03));
        add_vec(32'hFE2101B3, 32'h48, ex("ill_f7", 0, 0, 0, 0, 0, 5'd0, 3'd0, 4'h0, 8'h03));
        add_vec(32'hFFC0B203, 32'h4C, ex("ill_ld", 0, 0, 0, 0, 0, 5'd0, 3'd0, 4'h0, 8'h03));
        add_vec(32'h40209093, 32'h50, ex("ill_slli", 0, 0, 0, 0, 0, 5'd0, 3'd0, 4'h0, 8'h03));
        add_vec(32'h00000000, 32'h54, ex("bubble", 0, 0, 0, 0, 0, 5'd0, 3'd0, 4'h0, 8'h00));

        cyc(1, 0, 0, 5'd0, 0, 32'h00500093, 32'h10,
            ex("reset", 1, 0, 0, 0, 0, 5'd0, 3'd0, 4'h0, 8'h00));
        cyc(1, 1, 1, 5'd1, 32'h1, 32'h00500093, 32'h10,
            ex("reset2", 1, 0, 0, 0, 0, 5'd0, 3'd0, 4'h0, 8'h00));

        for (int i = 0; i < tbl.size(); i++)
            cyc(0, 0, 0, 5'd0, 0, tbl[i].inst, tbl[i].pc, tbl[i].e);

        // same-cycle write-back and read of x2
        cyc(0, 0, 1, 5'd2, 32'h11111111, 32'h0, 32'h0, idle("wr_x2"));
        cyc(0, 0, 1, 5'd2, 32'hDEADBEEF, 32'h002101B3, 32'h60,
            ex("bypass", 1, BYP_X2, BYP_X2, 0, 32'h60, 5'd3, 3'd0, 4'h0, 8'h05));
        cyc(0, 0, 0, 5'd0, 0, 32'h002101B3, 32'h64,
            ex("x2_after", 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h64, 5'd3, 3'd0, 4'h0, 8'h05));

        // x0 stays zero, with and without a concurrent write
        cyc(0, 0, 1, 5'd0, 32'd7, 32'h0, 32'h0, idle("wr_x0"));
        cyc(0, 0, 1, 5'd0, 32'd7, 32'h000001B3, 32'h68,
            ex("x0_read", 1, 0, 0, 0, 32'h68, 5'd3, 3'd0, 4'h0, 8'h05));

        // flush with a concurrent write that must still land
        cyc(0, 1, 1, 5'd5, 32'h55, 32'h002101B3, 32'h6C, idle("flush"));
        cyc(0, 0, 0, 5'd0, 0, 32'h000281B3, 32'h70,
            ex("x5_after_flush", 1, 32'h55, 0, 0, 32'h70, 5'd3, 3'd0, 4'h0, 8'h05));

        for (int i = 1; i < 32; i++)
            cyc(0, 0, 1, 5'(i), 32'hA5000000 | 32'(i), 32'h0, 32'h0, idle("fill"));
        cyc(0, 0, 0, 5'd0, 0, 32'h001F81B3, 32'h74,
            ex("x31_x1", 1, 32'hA500001F, 32'hA5000001, 0, 32'h74, 5'd3, 3'd0, 4'h0, 8'h05));

        cyc(1, 1, 1, 5'd1, 32'd9, 32'h00500093, 32'h78,
            ex("rst_mid", 1, 0, 0, 0, 0, 5'd0, 3'd0, 4'h0, 8'h00));
        for (int i = 1; i < 32; i++) begin
            ins = 32'h000001B3 | (32'(i) << 15) | (32'(i) << 20);
            cyc(0, 0, 0, 5'd0, 0, ins, 32'h100 + 32'(4 * i),
                ex("rd_cleared", 1, 0, 0, 0, 32'h100 + 32'(4 * i),
                   5'd3, 3'd0, 4'h0, 8'h05));
        end

        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have input InstrD (32 bits): instruction from the fetch pipeline register.
REQ-003 SHALL have input PC_DE (32 bits): PC of InstrD.
REQ-004 SHALL have input PC_R (1 bit): redirect/flush from execute.
REQ-005 SHALL have write-back inputs: WB_WE (1 bit) write enable; WB_A (5 bits) destination register; WB_D (32 bits) write data.
REQ-006 SHALL have outputs RS1_V_E and RS2_V_E (32 bits each): source operand values.
REQ-007 SHALL have outputs IMM_E and PC_E (32 bits each): sign-extended immediate; PC forwarded to execute.
REQ-008 SHALL have outputs RD_E (5 bits) and FUNCT3_E (3 bits): destination register; raw funct3.
REQ-009 SHALL have output ALU_OP_E (4 bits): {funct7[5], funct3} for OP and SRAI; 4'b0000 (ADD) otherwise.
REQ-010 SHALL have 1-bit control outputs: ALU_SRC_E (1 = use immediate), BRANCH_E, JUMP_E, MEM_RE_E, MEM_WE_E, REG_WE_E, ILLEGAL_E, VALID_E.

Function
REQ-011 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
REQ-012 SHALL register every *_E output on the clk edge following InstrD/PC_DE: one-cycle latency, no combinational path from inputs to outputs.
REQ-013 SHALL form IMM_E by format: I, S, B and J immediates sign-extended to 32 bits; U immediate = inst[31:12] << 12.
REQ-014 SHALL read operands rs1 = inst[19:15] and rs2 = inst[24:20] from a 32x32 register file.
REQ-015 SHALL write WB_D to register WB_A at the clk edge when WB_WE = 1 and WB_A != 0.
REQ-016 SHALL hardwire x0 to zero: reads return 0; writes to x0 are ignored.
REQ-017 SHALL treat InstrD = 0x00000000 (fetch bubble) as a bubble: VALID_E = 0, ILLEGAL_E = 0, all enables 0.
REQ-018 SHALL, for any unsupported opcode or a reserved funct3/funct7 combination, set VALID_E = 1 and ILLEGAL_E = 1, with REG_WE_E, MEM_RE_E, MEM_WE_E, BRANCH_E and JUMP_E all 0.
REQ-019 SHALL, when PC_R = 1 at a clk edge, load a bubble into the E register (VALID_E = 0, all enables 0); register-file writes in that cycle still occur.
REQ-020 SHALL drive REG_WE_E = 0 when rd = 0, regardless of opcode.
REQ-021 SHALL set PC_E = PC_DE for every valid instruction.

Reset
REQ-022 SHALL, on rst = 1 at a clk edge, clear all *_E outputs to 0 and all 31 architectural registers to 0.
REQ-023 SHALL give rst priority over PC_R and WB_WE when they are asserted together; reset asserted mid-stream discards the in-flight instruction.

Configuration
REQ-024 SHALL, with DECODE_BYPASS_EN defined, return WB_D for any rs1/rs2 equal to a nonzero WB_A while WB_WE = 1 in the same cycle (write-through forwarding).
REQ-025 SHALL, without DECODE_BYPASS_EN, return the pre-write register value in that case; the hazard is then the pipeline's responsibility.

Structure
REQ-026 SHALL take the opcode constants, the ALU_OP encodings and the 32-bit width constant from the shared package/header.
REQ-027 SHALL implement the register file as sub-module reg_file (two combinational read ports, one synchronous write port), with the x0 and bypass rules applied inside it.

Verification
REQ-028 SHALL verify: InstrD = 0x00500093 (addi x1,x0,5), PC_DE = 0x10 -> next cycle IMM_E = 5, RD_E = 1, ALU_SRC_E = 1, REG_WE_E = 1, PC_E = 0x10, VALID_E = 1.
REQ-029 SHALL verify: InstrD = 0x123452B7 (lui x5) -> IMM_E = 0x12345000, RD_E = 5, REG_WE_E = 1.
REQ-030 SHALL verify: WB_WE = 1, WB_A = 2, WB_D = 0xDEADBEEF concurrent with InstrD = 0x002101B3 (add x3,x2,x2) -> RS1_V_E = RS2_V_E = 0xDEADBEEF with DECODE_BYPASS_EN, old x2 value without it.
REQ-031 SHALL verify: write 7 to x0, then read x0 -> 0; InstrD = 0xFFFFFFFF -> ILLEGAL_E = 1, VALID_E = 1, REG_WE_E = 0.
REQ-032 SHALL verify: PC_R = 1 with a valid add in decode -> VALID_E = 0 and REG_WE_E = 0 next cycle.
REQ-033 SHALL verify: rst = 1 mid-stream -> all outputs 0 next cycle and subsequent reads of x1..x31 return 0.
